// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage.
package fetch_pkg;

  localparam int unsigned DefAddrSize = 16;
  localparam int unsigned DefDataSize = 16;
  localparam int unsigned DefResetPc  = 0;

  typedef struct packed {
    logic [DefAddrSize-1:0] addr;
    logic [DefDataSize-1:0] data;
  } fetch_entry_t;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a registered first-word-fall-through head.
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             head,
  output logic [clog2(Depth+1)-1:0]    count,
  output logic                         empty
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, wr_nxt, rd_nxt;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CntW'(Depth)) || do_pop);
  assign wr_nxt  = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
  assign rd_nxt  = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;

  // The head register always mirrors the entry at the read pointer.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (clear) begin
      count_d = '0;
    end else begin
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
      if (do_pop) begin
        if (count_q > CntW'(1)) head_d = mem_q[rd_nxt];
        else if (do_push) head_d = wdata;
      end else if (do_push && (count_q == '0)) begin
        head_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_nxt;
        if (do_pop)  rd_ptr_q <= rd_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = head_q;
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage issuing pipelined Wishbone reads into a prefetch FIFO, with
// credit-limited requests and flush-on-new-PC from DECODE.
module fetch_prefetch import fetch_pkg::*; #(
  parameter int unsigned G_ADDR_SIZE       = DefAddrSize,
  parameter int unsigned G_DATA_SIZE       = DefDataSize,
  parameter int unsigned G_MAX_OUTSTANDING = 4,
  parameter int unsigned G_RESET_PC        = DefResetPc
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  input  logic                   wb_stall_i,
  output logic [G_ADDR_SIZE-1:0] wb_addr_o,
  input  logic                   wb_ack_i,
  input  logic [G_DATA_SIZE-1:0] wb_data_i,
  output logic                   dc_valid_o,
  input  logic                   dc_ready_i,
  output logic [G_ADDR_SIZE-1:0] dc_addr_o,
  output logic [G_DATA_SIZE-1:0] dc_data_o,
  input  logic                   dc_valid_i,
  input  logic [G_ADDR_SIZE-1:0] dc_addr_i
);

  localparam int unsigned CntW = clog2(G_MAX_OUTSTANDING + 1);
  localparam int unsigned EntW = G_ADDR_SIZE + G_DATA_SIZE;
  localparam logic [G_ADDR_SIZE-1:0] ResetPc = G_ADDR_SIZE'(G_RESET_PC);
  localparam logic [CntW:0] MaxOut = (CntW + 1)'(G_MAX_OUTSTANDING);

  logic                   cyc_q, cyc_d, stb_q, stb_d;
  logic [G_ADDR_SIZE-1:0] addr_q, addr_d, resp_pc_q, resp_pc_d;
  logic [CntW-1:0]        out_q, out_d, fifo_cnt, fifo_cnt_d;
  logic                   flush, accept, ack_ok, pop, fifo_empty;
  logic [EntW-1:0]        head;

  assign flush  = dc_valid_i;
  assign accept = stb_q & ~wb_stall_i;
  assign ack_ok = wb_ack_i & cyc_q & (out_q != '0);
  assign pop    = ~fifo_empty & dc_ready_i & ~flush;

  // Strobe is computed from post-edge counts so credits account for this
  // cycle's accept, ack and pop; a stalled strobe is simply held.
  always_comb begin
    out_d      = out_q;
    fifo_cnt_d = fifo_cnt;
    addr_d     = addr_q;
    resp_pc_d  = resp_pc_q;
    stb_d      = 1'b0;
    cyc_d      = 1'b0;
    if (flush) begin
      out_d      = '0;
      fifo_cnt_d = '0;
      addr_d     = dc_addr_i;
      resp_pc_d  = dc_addr_i;
    end else begin
      if (accept && !ack_ok) out_d = out_q + 1'b1;
      else if (!accept && ack_ok) out_d = out_q - 1'b1;
      if (ack_ok && !pop) fifo_cnt_d = fifo_cnt + 1'b1;
      else if (!ack_ok && pop) fifo_cnt_d = fifo_cnt - 1'b1;
      if (accept) addr_d = addr_q + 1'b1;
      if (ack_ok) resp_pc_d = resp_pc_q + 1'b1;
      stb_d = (stb_q && wb_stall_i) || (({1'b0, out_d} + {1'b0, fifo_cnt_d}) < MaxOut);
      cyc_d = stb_d || (out_d != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      addr_q    <= ResetPc;
      resp_pc_q <= ResetPc;
      out_q     <= '0;
    end else begin
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
    end
  end

  fetch_fifo #(
    .Depth(G_MAX_OUTSTANDING),
    .Width(EntW)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .clear(flush),
    .push (ack_ok & ~flush),
    .wdata({resp_pc_q, wb_data_i}),
    .pop  (pop),
    .head (head),
    .count(fifo_cnt),
    .empty(fifo_empty)
  );

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_addr_o  = addr_q;
  assign dc_valid_o = ~fifo_empty;
  assign dc_addr_o  = head[EntW-1 -: G_ADDR_SIZE];
  assign dc_data_o  = head[G_DATA_SIZE-1:0];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomised bench for fetch_prefetch: a Wishbone memory model feeds an
// expected-delivery queue that a separate DECODE-side monitor drains.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned MAXO = 4;
  localparam logic [AW-1:0] RPC = 16'h0000;

  logic clk = 1'b0, rst = 1'b1;
  logic wb_cyc_o, wb_stb_o, wb_stall_i = 1'b0, wb_ack_i = 1'b0;
  logic [AW-1:0] wb_addr_o, dc_addr_o, dc_addr_i = '0;
  logic [DW-1:0] wb_data_i = '0, dc_data_o;
  logic dc_valid_o, dc_ready_i = 1'b0, dc_valid_i = 1'b0;

  fetch_prefetch #(
    .G_ADDR_SIZE(AW), .G_DATA_SIZE(DW), .G_MAX_OUTSTANDING(MAXO), .G_RESET_PC(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_stall_i(wb_stall_i), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i),
    .wb_data_i(wb_data_i), .dc_valid_o(dc_valid_o), .dc_ready_i(dc_ready_i),
    .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_valid_i(dc_valid_i),
    .dc_addr_i(dc_addr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   cyc;
  } req_t;

  int n_checks = 0, n_fail = 0;
  req_t pending[$];
  fetch_entry_t sb[$];
  logic [AW-1:0] exp_issue = RPC, prev_addr = '0, flush_tgt = '0, flush_addr = '0;
  logic [AW-1:0] last_pop = '0;
  logic hold_prev = 1'b0, flush_req = 1'b0, wrap_seen = 1'b0;
  int unsigned cycle = 0, accepts = 0, flush_age = 99, stall_left = 0;
  int unsigned stall_pct = 0, ack_pct = 100, ready_pct = 100, spur_pct = 10;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5a, a[15:8] + 8'h3c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_addr", wb_addr_o, RPC);
    check("rst_dc_valid", dc_valid_o, 0);
    check("rst_dc_addr", dc_addr_o, 0);
    check("rst_dc_data", dc_data_o, 0);
    wb_ack_i = 1'b1;  // stale acks during reset must vanish
    dc_valid_i = 1'b0;
    dc_ready_i = 1'b0;
    wb_stall_i = 1'b0;
    pending.delete();
    sb.delete();
    exp_issue = RPC;
    flush_age = 99;
    hold_prev = 1'b0;
    accepts = 0;
    repeat (2) @(negedge clk);
    wb_ack_i = 1'b0;
    rst = 1'b0;
  endtask

  // One cycle: check outputs settled from the last edge, then drive and
  // account for what the coming edge does.
  task automatic step();
    logic acc, do_ack, flush;
    @(negedge clk);
    cycle++;
    flush = flush_req;
    flush_req = 1'b0;
    if (flush_age < 99) flush_age++;

    check("dc_valid", dc_valid_o, sb.size() != 0);
    check("stb_implies_cyc", wb_stb_o & ~wb_cyc_o, 0);
    if (pending.size() != 0) check("cyc_outstanding", wb_cyc_o, 1);
    if (wb_stb_o) check("credit", pending.size() + sb.size() < MAXO, 1);
    if (hold_prev) begin
      check("stall_stb", wb_stb_o, 1);
      check("stall_addr", wb_addr_o, prev_addr);
    end
    if (flush_age == 1) begin
      check("flush_cyc", wb_cyc_o, 0);
      check("flush_stb", wb_stb_o, 0);
    end
    if (flush_age == 2) begin
      check("restart_stb", wb_stb_o, 1);
      check("restart_addr", wb_addr_o, flush_tgt);
    end

    wb_stall_i = ($urandom_range(99) < stall_pct);
    if (stall_left > 0 && wb_stb_o && wb_addr_o == 16'h0002) begin
      wb_stall_i = 1'b1;
      stall_left--;
    end
    dc_ready_i = ($urandom_range(99) < ready_pct);
    dc_valid_i = flush;
    dc_addr_i  = flush ? flush_addr : AW'($urandom);
    do_ack = (pending.size() != 0) && (pending[0].cyc < cycle) &&
             ($urandom_range(99) < ack_pct);
    wb_ack_i  = 1'b0;
    wb_data_i = DW'($urandom);
    if (do_ack) begin
      wb_ack_i  = 1'b1;
      wb_data_i = mem(pending[0].addr);
    end else if (pending.size() == 0 && $urandom_range(99) < spur_pct) begin
      wb_ack_i = 1'b1;
    end
    acc = wb_stb_o && !wb_stall_i;
    hold_prev = wb_stb_o && wb_stall_i && !flush;
    prev_addr = wb_addr_o;

    if (flush) begin
      pending.delete();
      sb.delete();
      exp_issue = flush_addr;
      flush_tgt = flush_addr;
      flush_age = 0;
    end else begin
      if (do_ack) begin
        sb.push_back('{addr: pending[0].addr, data: mem(pending[0].addr)});
        void'(pending.pop_front());
      end
      if (acc) begin
        check("issue_addr", wb_addr_o, exp_issue);
        exp_issue++;
        accepts++;
        pending.push_back('{addr: wb_addr_o, cyc: cycle});
      end
    end
  endtask

  // DECODE-side monitor.
  logic mon_hold = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  logic [DW-1:0] mon_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mon_hold = 1'b0;
        continue;
      end
      if (mon_hold) begin
        check("dc_hold_valid", dc_valid_o, 1);
        check("dc_hold_addr", dc_addr_o, mon_addr);
        check("dc_hold_data", dc_data_o, mon_data);
      end
      if (dc_valid_o && dc_ready_i && !dc_valid_i) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          check("dc_addr", dc_addr_o, sb[0].addr);
          check("dc_data", dc_data_o, sb[0].data);
          void'(sb.pop_front());
        end
        if (last_pop == 16'hffff && dc_addr_o == 16'h0000) wrap_seen = 1'b1;
        last_pop = dc_addr_o;
      end
      mon_hold = dc_valid_o && !dc_ready_i && !dc_valid_i;
      mon_addr = dc_addr_o;
      mon_data = dc_data_o;
    end
  end

  initial begin
    int n;
    // 1: streaming, one delivery per cycle once warmed up
    do_reset();
    stall_pct = 0; ack_pct = 100; ready_pct = 100; spur_pct = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 6) check("stream_valid", dc_valid_o, 1);
    end

    // 2: credits exhausted with DECODE blocked; one pop frees one request
    do_reset();
    ready_pct = 0;
    repeat (12) step();
    check("fill_count", sb.size(), MAXO);
    check("fill_accepts", accepts, MAXO);
    check("fill_stb", wb_stb_o, 0);
    ready_pct = 100;
    step();
    ready_pct = 0;
    repeat (6) step();
    check("refill_accepts", accepts, MAXO + 1);
    check("refill_count", sb.size(), MAXO);

    // 3: stall held on address 0002
    do_reset();
    ready_pct = 100;
    stall_left = 3;
    repeat (20) step();
    check("stall_seen", stall_left, 0);

    // 4: flush with two requests in flight, plus late acks
    do_reset();
    ack_pct = 0;
    n = 0;
    while (pending.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("two_in_flight", pending.size(), 2);
    ack_pct = 100; spur_pct = 100;
    flush_req = 1'b1; flush_addr = 16'h0100;
    step();
    step();
    spur_pct = 0;
    repeat (12) step();

    // 5: flush near the top of the address space
    flush_req = 1'b1; flush_addr = 16'hfffe;
    wrap_seen = 1'b0;
    repeat (16) step();
    check("wrap_seen", wrap_seen, 1);

    // 6: reset with three requests outstanding
    ack_pct = 0;
    n = 0;
    while (pending.size() < 3 && n < 20) begin
      step();
      n++;
    end
    check("three_in_flight", pending.size(), 3);
    do_reset();
    ack_pct = 100; spur_pct = 100;
    repeat (20) step();
    check("restart_accepts", accepts > 0, 1);

    // 7: random mix with flushes
    stall_pct = 30; ack_pct = 60; ready_pct = 60; spur_pct = 10;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 3) begin
        flush_req = 1'b1;
        flush_addr = ($urandom_range(3) == 0) ? 16'hfffc + AW'($urandom_range(3))
                                              : AW'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
